// File: rtl/locked_adder_response_checker_if.sv
// Sample stream into the response checker: operand pair, the locked adder's
// observed sum and a valid/ready handshake.
interface locked_adder_response_checker_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic [WIDTH:0]   result_o;

  modport master (output in_valid, add1_i, add2_i, result_o, input in_ready);
  modport slave  (input in_valid, add1_i, add2_i, result_o, output in_ready);
endinterface

// File: rtl/locked_adder_response_checker.sv
// Session-based response checker for a key-locked adder: per-sample Hamming
// distance against the golden sum plus mismatch / bit-error / max-HD statistics.
module locked_adder_response_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int SUM_W = 24,
  localparam int HD_W = $clog2(WIDTH + 2)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_samples,
  locked_adder_response_checker_if.slave smp,
  output logic                           hd_valid,
  output logic [HD_W-1:0]                hd_out,
  output logic [CNT_W-1:0]               mismatch_count,
  output logic [SUM_W-1:0]               bit_error_sum,
  output logic [HD_W-1:0]                max_hd,
  output logic                           busy,
  output logic                           done
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  function automatic logic [HD_W-1:0] popcount(input logic [WIDTH:0] v);
    logic [HD_W-1:0] c;
    c = {HD_W{1'b0}};
    for (int i = 0; i <= WIDTH; i++) begin
      c = c + {{(HD_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             s1_valid_q;
  logic [WIDTH:0]   diff_q;
  logic             hd_valid_q;
  logic [HD_W-1:0]  hd_out_q;
  logic [HD_W-1:0]  max_hd_q;
  logic [CNT_W-1:0] mismatch_q;
  logic [SUM_W-1:0] bit_sum_q;

  logic             start_acc_s;
  logic             accept_s;
  logic             last_acc_s;
  logic [WIDTH:0]   diff_d;
  logic [HD_W-1:0]  hd_d;
  logic [SUM_W:0]   sum_ext_s;
  logic [SUM_W-1:0] bit_sum_d;
  logic [CNT_W-1:0] mismatch_d;
  logic [HD_W-1:0]  max_hd_d;

  // Handshake qualification, golden-sum difference and saturating statistic updates.
  always_comb begin
    start_acc_s = start && ((state_q == IDLE) || (state_q == DONE));
    accept_s    = smp.in_valid && in_ready_q;
    last_acc_s  = ((acc_cnt_q + CNT_ONE) == len_q);
    diff_d      = ({1'b0, smp.add1_i} + {1'b0, smp.add2_i}) ^ smp.result_o;
    hd_d        = popcount(diff_q);
    sum_ext_s   = {1'b0, bit_sum_q} + {{(SUM_W + 1 - HD_W){1'b0}}, hd_d};
    if (sum_ext_s[SUM_W]) begin
      bit_sum_d = SUM_MAX;
    end else begin
      bit_sum_d = sum_ext_s[SUM_W-1:0];
    end
    if ((hd_d != {HD_W{1'b0}}) && (mismatch_q != CNT_MAX)) begin
      mismatch_d = mismatch_q + CNT_ONE;
    end else begin
      mismatch_d = mismatch_q;
    end
    if (hd_d > max_hd_q) begin
      max_hd_d = hd_d;
    end else begin
      max_hd_d = max_hd_q;
    end
  end

  // Session FSM with registered in_ready / busy / done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= {CNT_W{1'b0}};
      acc_cnt_q  <= {CNT_W{1'b0}};
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_q     <= num_samples;
            acc_cnt_q <= {CNT_W{1'b0}};
            if (num_samples == {CNT_W{1'b0}}) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept_s) begin
            acc_cnt_q <= acc_cnt_q + CNT_ONE;
            if (last_acc_s) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Stage 2 has finished its last update once stage 1 is empty.
          if (!s1_valid_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage datapath: stage 1 holds the difference, stage 2 its popcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      diff_q     <= {(WIDTH + 1){1'b0}};
      hd_valid_q <= 1'b0;
      hd_out_q   <= {HD_W{1'b0}};
    end else begin
      s1_valid_q <= accept_s;
      hd_valid_q <= s1_valid_q;
      if (accept_s) begin
        diff_q <= diff_d;
      end
      if (s1_valid_q) begin
        hd_out_q <= hd_d;
      end
    end
  end

  // Session statistics: cleared by an honoured start, updated in stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= {CNT_W{1'b0}};
      bit_sum_q  <= {SUM_W{1'b0}};
      max_hd_q   <= {HD_W{1'b0}};
    end else if (start_acc_s) begin
      mismatch_q <= {CNT_W{1'b0}};
      bit_sum_q  <= {SUM_W{1'b0}};
      max_hd_q   <= {HD_W{1'b0}};
    end else if (s1_valid_q) begin
      mismatch_q <= mismatch_d;
      bit_sum_q  <= bit_sum_d;
      max_hd_q   <= max_hd_d;
    end
  end

  assign smp.in_ready    = in_ready_q;
  assign hd_valid        = hd_valid_q;
  assign hd_out          = hd_out_q;
  assign mismatch_count  = mismatch_q;
  assign bit_error_sum   = bit_sum_q;
  assign max_hd          = max_hd_q;
  assign busy            = busy_q;
  assign done            = done_q;
endmodule

// File: tb/tb_locked_adder_response_checker.sv
// Bench for locked_adder_response_checker: queue-based reference model checked
// every cycle, random flow control, and hand-computed directed sessions.
module tb_locked_adder_response_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = 16'd0;
  logic        hd_valid;
  logic [4:0]  hd_out;
  logic [15:0] mismatch_count;
  logic [23:0] bit_error_sum;
  logic [4:0]  max_hd;
  logic        busy;
  logic        done;

  locked_adder_response_checker_if #(.WIDTH(16)) smp ();

  locked_adder_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .smp(smp), .hd_valid(hd_valid), .hd_out(hd_out),
    .mismatch_count(mismatch_count), .bit_error_sum(bit_error_sum),
    .max_hd(max_hd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_hdv = -100;
  int hdv_count = 0;
  int hd_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected HD per accepted sample and session-level state.
  typedef struct { int hd; int cyc; } exp_t;
  exp_t exp_q[$];
  longint m_mis, m_sum, m_max;
  int     m_len, m_acc;
  bit     m_busy, m_done;

  function automatic int golden_hd(input logic [15:0] a, input logic [15:0] b,
                                   input logic [16:0] r);
    logic [16:0] g;
    g = 17'(a) + 17'(b);
    return $countones(g ^ r);
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    bit   last_now;
    if (!rst_n) begin
      exp_q.delete();
      m_mis = 0; m_sum = 0; m_max = 0; m_len = 0; m_acc = 0;
      m_busy = 1'b0; m_done = 1'b0;
      chk("rst_hd_valid", hd_valid, 0);
      chk("rst_in_ready", smp.in_ready, 0);
      chk("rst_mismatch", mismatch_count, 0);
      chk("rst_bit_sum", bit_error_sum, 0);
      chk("rst_max_hd", max_hd, 0);
      chk("rst_done", done, 0);
    end else begin
      last_now = 1'b0;
      if (hd_valid) begin
        if (exp_q.size() == 0) begin
          chk("hd_valid_spurious", hd_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("hd_out", hd_out, e.hd);
          chk("hd_latency", cyc, e.cyc + 2);
          if (e.hd != 0 && m_mis < 65535) m_mis++;
          m_sum = (m_sum + e.hd > 24'hFFFFFF) ? 24'hFFFFFF : m_sum + e.hd;
          if (e.hd > m_max) m_max = e.hd;
          last_hdv = cyc;
          hdv_count++;
          hd_log.push_back(int'(hd_out));
          last_now = (m_acc == m_len) && (exp_q.size() == 0);
        end
      end
      chk("mismatch_count", mismatch_count, m_mis);
      chk("bit_error_sum", bit_error_sum, m_sum);
      chk("max_hd", max_hd, m_max);
      chk("in_ready", smp.in_ready, (m_busy && m_acc < m_len) ? 1 : 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      // Apply what the coming edge will see.
      if (smp.in_valid && m_busy && m_acc < m_len) begin
        e.hd  = golden_hd(smp.add1_i, smp.add2_i, smp.result_o);
        e.cyc = cyc;
        exp_q.push_back(e);
        m_acc++;
      end
      if (last_now && m_busy) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else if (start && !m_busy) begin
        m_mis = 0; m_sum = 0; m_max = 0;
        m_len = int'(num_samples); m_acc = 0;
        if (num_samples == 16'd0) begin
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_done = 1'b0;
        end
      end
    end
  end

  // Tasks enter and leave 1 time unit after a rising edge.
  task automatic start_session(input int n);
    start = 1'b1;
    num_samples = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_sample(input logic [15:0] a, input logic [15:0] b,
                              input logic [16:0] r);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    smp.in_valid = 1'b1;
    smp.add1_i = a;
    smp.add2_i = b;
    smp.result_o = r;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = smp.in_ready;
      @(posedge clk); #1;
      t++;
    end
    smp.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", smp.in_ready, 1);
  endtask

  task automatic wait_done(input int bound, output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int t = 0; t < bound && !seen; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    if (!seen) chk("done_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dc, hbase;
    logic [15:0] a, b;
    logic [16:0] g, r;
    smp.in_valid = 1'b0;
    smp.add1_i = 16'd0;
    smp.add2_i = 16'd0;
    smp.result_o = 17'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_reset_in_ready", smp.in_ready, 0);
    chk("post_reset_busy", busy, 0);

    // in_valid while IDLE must be ignored.
    smp.in_valid = 1'b1;
    smp.result_o = 17'h1FFFF;
    repeat (4) @(posedge clk);
    #1 smp.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_hd_valid", hdv_count, 0);

    // Correct key: all observed sums equal the golden sums.
    hd_log.delete();
    start_session(4);
    drive_sample(16'h0001, 16'h0002, 17'h00003);
    drive_sample(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    drive_sample(16'h8000, 16'h8000, 17'h10000);
    drive_sample(16'h0000, 16'h0000, 17'h00000);
    wait_done(20, dc);
    chk("ck_hd_count", hd_log.size(), 4);
    for (int i = 0; i < 4 && i < hd_log.size(); i++) chk("ck_hd", hd_log[i], 0);
    chk("ck_mismatch", mismatch_count, 0);
    chk("ck_bit_sum", bit_error_sum, 0);
    chk("ck_max_hd", max_hd, 0);
    chk("ck_done_latency", dc - last_hdv, 1);

    // Corrupted carry-out.
    hd_log.delete();
    start_session(1);
    drive_sample(16'hFFFF, 16'h0001, 17'h00000);
    wait_done(20, dc);
    chk("carry_hd", (hd_log.size() > 0) ? hd_log[0] : -1, 1);
    chk("carry_mismatch", mismatch_count, 1);
    chk("carry_bit_sum", bit_error_sum, 1);
    chk("carry_max_hd", max_hd, 1);

    // Full inversion then a 3-bit error.
    hd_log.delete();
    start_session(2);
    drive_sample(16'h0000, 16'h0000, 17'h1FFFF);
    drive_sample(16'h0001, 16'h0002, 17'h00004);
    wait_done(20, dc);
    chk("inv_hd0", (hd_log.size() > 0) ? hd_log[0] : -1, 17);
    chk("inv_hd1", (hd_log.size() > 1) ? hd_log[1] : -1, 3);
    chk("inv_mismatch", mismatch_count, 2);
    chk("inv_bit_sum", bit_error_sum, 20);
    chk("inv_max_hd", max_hd, 17);
    chk("inv_done_latency", dc - last_hdv, 1);

    // Zero-length session from DONE: clears statistics, DONE after one edge.
    start_session(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_mismatch", mismatch_count, 0);
    chk("zero_bit_sum", bit_error_sum, 0);
    chk("zero_max_hd", max_hd, 0);

    // Random flow control with a start pulse while busy.
    hbase = hdv_count;
    start_session(10000);
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        start = 1'b1;
        num_samples = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        smp.in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
        end
      end
      a = 16'($urandom);
      b = 16'($urandom);
      g = 17'(a) + 17'(b);
      case ($urandom_range(0, 3))
        0:       r = g;
        1:       r = g ^ (17'd1 << $urandom_range(0, 16));
        2:       r = ~g;
        default: r = 17'($urandom);
      endcase
      drive_sample(a, b, r);
    end
    wait_done(20, dc);
    chk("flow_hd_valid_count", hdv_count - hbase, 10000);
    chk("flow_done_in_ready", smp.in_ready, 0);

    // in_valid while DONE must be ignored.
    hbase = hdv_count;
    smp.in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 smp.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("done_no_hd_valid", hdv_count - hbase, 0);

    // Asynchronous reset with samples in flight.
    start_session(5);
    drive_sample(16'h1234, 16'h4321, 17'h00000);
    drive_sample(16'hAAAA, 16'h5555, 17'h1FFFF);
    rst_n = 1'b0;
    #1;
    chk("arst_hd_valid", hd_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", smp.in_ready, 0);
    chk("arst_mismatch", mismatch_count, 0);
    hbase = hdv_count;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_hd_valid", hdv_count - hbase, 0);
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
